// File: rtl/updown_pkg.sv
// Shared encodings for the up/down step sequencer: FSM states, direction and owner codes.
package updown_pkg;

  localparam int unsigned LEN_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves to the losing side on every advance.
module rr_arbiter2
  import updown_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic advance,
  output logic owner
);

  logic ptr_r;

  // A lone request wins; a tie goes to the pointer's side.
  always_comb begin
    owner = OWN_A;
    if (req_a && req_b) begin
      owner = ptr_r;
    end else if (req_b) begin
      owner = OWN_B;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r <= OWN_A;
    end else if (advance) begin
      ptr_r <= ~owner;
    end
  end

endmodule

// File: rtl/updown_step_sequencer.sv
// Shares one up/down counter between requesters A and B, driving cnt_en/cnt_up for
// exactly len cycles per granted burst, with registered Moore outputs.
module updown_step_sequencer
  import updown_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_a,
  input  logic             up_a,
  input  logic [LEN_W-1:0] len_a,
  input  logic             req_b,
  input  logic             up_b,
  input  logic [LEN_W-1:0] len_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy
);

  state_t           state_r, state_d;
  logic             owner_r, owner_d;
  logic             dir_r, dir_d;
  logic [LEN_W-1:0] rem_r, rem_d;
  logic             arb_owner;
  logic             start;
  logic             own_up;
  logic [LEN_W-1:0] own_len;

  logic gnt_a_d, gnt_b_d, done_a_d, done_b_d, cnt_en_d, cnt_up_d, busy_d;

  assign start   = (state_r == ST_IDLE) && (req_a || req_b);
  assign own_up  = (owner_r == OWN_B) ? up_b : up_a;
  assign own_len = (owner_r == OWN_B) ? len_b : len_a;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req_a   (req_a),
    .req_b   (req_b),
    .advance (start),
    .owner   (arb_owner)
  );

  // State and burst context registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_A;
      dir_r   <= DIR_DN;
      rem_r   <= '0;
    end else begin
      state_r <= state_d;
      owner_r <= owner_d;
      dir_r   <= dir_d;
      rem_r   <= rem_d;
    end
  end

  // Next state; the owner's direction/length are captured on the edge leaving GRANT.
  always_comb begin
    state_d = state_r;
    owner_d = owner_r;
    dir_d   = dir_r;
    rem_d   = rem_r;
    unique case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_GRANT;
          owner_d = arb_owner;
        end
      end
      ST_GRANT: begin
        dir_d   = own_up;
        rem_d   = own_len;
        state_d = (own_len == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        rem_d = rem_r - LEN_W'(1);
        if (rem_r == LEN_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    cnt_en_d = 1'b0;
    cnt_up_d = DIR_DN;
    busy_d   = (state_d != ST_IDLE);
    unique case (state_d)
      ST_GRANT: begin
        gnt_a_d = (owner_d == OWN_A);
        gnt_b_d = (owner_d == OWN_B);
      end
      ST_RUN: begin
        cnt_en_d = 1'b1;
        cnt_up_d = dir_d;
      end
      ST_DONE: begin
        done_a_d = (owner_d == OWN_A);
        done_b_d = (owner_d == OWN_B);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      cnt_en <= 1'b0;
      cnt_up <= 1'b0;
      busy   <= 1'b0;
    end else begin
      gnt_a  <= gnt_a_d;
      gnt_b  <= gnt_b_d;
      done_a <= done_a_d;
      done_b <= done_b_d;
      cnt_en <= cnt_en_d;
      cnt_up <= cnt_up_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_updown_step_sequencer.sv
// Directed, table-driven bench for updown_step_sequencer with a 2-bit counter model.
module tb_updown_step_sequencer;

  localparam int unsigned LEN_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_a, up_a, req_b, up_b;
  logic [LEN_W-1:0] len_a, len_b;
  logic             gnt_a, gnt_b, done_a, done_b, cnt_en, cnt_up, busy;

  always #5 clock = ~clock;

  updown_step_sequencer #(.LEN_W(LEN_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .req_a  (req_a),
    .up_a   (up_a),
    .len_a  (len_a),
    .req_b  (req_b),
    .up_b   (up_b),
    .len_b  (len_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .done_a (done_a),
    .done_b (done_b),
    .cnt_en (cnt_en),
    .cnt_up (cnt_up),
    .busy   (busy)
  );

  // 2-bit counter datapath driven by cnt_en/cnt_up.
  logic       model_load = 1'b0;
  logic [1:0] mcnt;
  int         msteps;
  always @(posedge clock) begin
    if (model_load) begin
      mcnt   <= 2'd3;
      msteps <= 0;
    end else if (cnt_en) begin
      mcnt   <= cnt_up ? mcnt + 2'd1 : mcnt - 2'd1;
      msteps <= msteps + 1;
    end
  end

  // Output vector order: {gnt_a, gnt_b, done_a, done_b, cnt_en, cnt_up, busy}
  typedef struct {
    logic             ra, ua;
    logic [LEN_W-1:0] la;
    logic             rb, ub;
    logic [LEN_W-1:0] lb;
    logic [6:0]       exp;
    string            name;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] outs();
    return {gnt_a, gnt_b, done_a, done_b, cnt_en, cnt_up, busy};
  endfunction

  function automatic vec_t mk(logic ra, logic ua, logic [LEN_W-1:0] la, logic rb, logic ub,
                              logic [LEN_W-1:0] lb, logic [6:0] exp, string name);
    vec_t v;
    v.ra = ra; v.ua = ua; v.la = la; v.rb = rb; v.ub = ub; v.lb = lb;
    v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic ra, logic ua, logic [LEN_W-1:0] la, logic rb, logic ub,
                       logic [LEN_W-1:0] lb);
    req_a = ra; up_a = ua; len_a = la;
    req_b = rb; up_b = ub; len_b = lb;
  endtask

  // Each row: inputs sampled on the next edge, outputs checked just after it.
  task automatic run_vecs();
    foreach (vecs[i]) begin
      drive(vecs[i].ra, vecs[i].ua, vecs[i].la, vecs[i].rb, vecs[i].ub, vecs[i].lb);
      step();
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

    // Reset held 3 cycles, then idle with no requests.
    repeat (3) step();
    check("reset_outputs", 32'(outs()), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_no_req", 32'(outs()), 32'd0);
    end

    // Single A burst, up, len 3.
    vecs.push_back(mk(1, 1, 4'd3, 0, 0, 4'd0, 7'b1000001, "t2_gnt_a"));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 4'd3, 0, 0, 4'd0, 7'b0000111, "t2_run_up"));
    vecs.push_back(mk(0, 1, 4'd3, 0, 0, 4'd0, 7'b0010001, "t2_done_a"));
    vecs.push_back(mk(0, 1, 4'd3, 0, 0, 4'd0, 7'b0000000, "t2_idle"));
    run_vecs();

    // Both held from a fresh pointer: A, B, A, B, each down by 2.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      vecs.push_back(mk(1, 0, 4'd2, 1, 0, 4'd2, (b % 2 == 1) ? 7'b0100001 : 7'b1000001,
                        "t3_gnt_order"));
      vecs.push_back(mk(1, 0, 4'd2, 1, 0, 4'd2, 7'b0000101, "t3_run_dn"));
      vecs.push_back(mk(1, 0, 4'd2, 1, 0, 4'd2, 7'b0000101, "t3_run_dn"));
      vecs.push_back(mk(1, 0, 4'd2, 1, 0, 4'd2, (b % 2 == 1) ? 7'b0001001 : 7'b0010001,
                        "t3_done_order"));
      vecs.push_back(mk(1, 0, 4'd2, 1, 0, 4'd2, 7'b0000000, "t3_idle_gap"));
    end
    vecs.push_back(mk(0, 0, 4'd2, 0, 0, 4'd2, 7'b0000000, "t3_quiet"));
    run_vecs();

    // Zero-length B burst: grant then done, no steps.
    vecs.push_back(mk(0, 0, 4'd0, 1, 1, 4'd0, 7'b0100001, "t4_gnt_b"));
    vecs.push_back(mk(0, 0, 4'd0, 0, 1, 4'd0, 7'b0001001, "t4_done_b"));
    vecs.push_back(mk(0, 0, 4'd0, 0, 1, 4'd0, 7'b0000000, "t4_idle"));
    run_vecs();

    // Long A burst aborted by reset after its 5th step.
    vecs.push_back(mk(1, 1, 4'd15, 0, 0, 4'd0, 7'b1000001, "t5_gnt_a"));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 4'd15, 0, 0, 4'd0, 7'b0000111, "t5_run"));
    run_vecs();
    #2 reset = 1'b1;
    #1 check("t5_async_abort", 32'(outs()), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_no_done", 32'(outs()), 32'd0);
    end
    vecs.push_back(mk(1, 1, 4'd1, 1, 1, 4'd1, 7'b1000001, "t5_ptr_at_a"));
    vecs.push_back(mk(0, 1, 4'd1, 0, 1, 4'd1, 7'b0000111, "t5_run_after"));
    vecs.push_back(mk(0, 1, 4'd1, 0, 1, 4'd1, 7'b0010001, "t5_done_after"));
    vecs.push_back(mk(0, 1, 4'd1, 0, 1, 4'd1, 7'b0000000, "t5_idle_after"));
    run_vecs();

    // Inputs changed after grant do not affect the burst; counter wraps 3->0->1.
    model_load = 1'b1;
    step();
    model_load = 1'b0;
    vecs.push_back(mk(1, 1, 4'd2, 0, 0, 4'd0, 7'b1000001, "t6_gnt_a"));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 4'd0, 7'b0000111, "t6_run1"));
    vecs.push_back(mk(0, 0, 4'd9, 0, 0, 4'd0, 7'b0000111, "t6_run2"));
    vecs.push_back(mk(0, 0, 4'd9, 0, 0, 4'd0, 7'b0010001, "t6_done_a"));
    vecs.push_back(mk(0, 0, 4'd9, 0, 0, 4'd0, 7'b0000000, "t6_idle"));
    run_vecs();
    check("t6_step_count", 32'(msteps), 32'd2);
    check("t6_counter_wrap", 32'(mcnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
